dcache_wb_buffer: RTL and testbench
===================================

Name: dcache_wb_buffer

Overview:
Write-back buffer between the data-cache controller and the off-chip Data_Memory. It absorbs dirty-line evictions so the cache gets a 1-cycle ack instead of waiting out the full memory latency. Buffered lines drain to memory in the background. Read misses bypass queued writes, with read-after-write hazards resolved by forwarding from the buffer. Both sides use the 256-bit line enable/ack protocol of Data_Memory.

Parameters:
DEPTH, 4, number of line entries (power of 2, >=2)
LINE_W, 256, line width in bits
ADDR_W, 32, byte address width; line tag = addr[ADDR_W-1:5]

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
c_addr_i  input  ADDR_W  cache request byte address
c_data_i  input  LINE_W  cache write line
c_enable_i  input  1  cache request valid, held until c_ack_o
c_write_i  input  1  1=write-back, 0=line read
c_ack_o  output  1  one-cycle completion pulse to cache
c_data_o  output  LINE_W  read line, valid in c_ack_o cycle
mem_addr_o  output  ADDR_W  memory address, line-aligned (low 5 bits 0)
mem_data_o  output  LINE_W  memory write line
mem_enable_o  output  1  memory request, held until mem_ack_i
mem_write_o  output  1  memory write select
mem_ack_i  input  1  memory one-cycle completion pulse
mem_data_i  input  LINE_W  memory read line, valid with mem_ack_i
count_o  output  clog2(DEPTH)+1  occupied entries
empty_o  output  1  count_o==0 and no memory write in flight

Behaviour:
- Reset (rst_i=0, async): all outputs 0 except empty_o=1. Count=0, FIFO pointers=0, FSM=IDLE. Buffered data is discarded, including any in-flight transaction. mem_enable_o drops immediately.
- Storage: circular FIFO of {tag, line}. Head = oldest entry. Pointers wrap modulo DEPTH.
- Cache write accept: evaluated on the cycle c_enable_i&c_write_i is high, using registered state.
  - If tag matches a non-head entry, or the head while not being drained: overwrite that entry's line (merge), count unchanged.
  - Else if count<DEPTH: push to tail.
  - Else (full): stall. Accept on the first cycle after a pop, never in the same cycle as the pop.
  - c_ack_o pulses exactly 1 cycle after acceptance.
- Cache read: tag compared against all valid entries, including a head currently draining.
  - Hit: c_data_o = entry line, c_ack_o pulses 1 cycle after request. No memory access.
  - Miss: the FSM issues a memory read.
- FSM: IDLE, DRAIN, READ, RESP.
  - IDLE -> READ when a cache read misses. Read misses have priority over draining.
  - IDLE -> DRAIN when count>0 and no read miss is pending.
  - DRAIN: mem_enable_o=1, mem_write_o=1, addr/data = head. On mem_ack_i, pop head and go to IDLE. An in-flight drain is never aborted; a read miss arriving meanwhile waits.
  - READ: mem_enable_o=1, mem_write_o=0, mem_addr_o = {c_addr_i[31:5],5'b0}. On mem_ack_i, latch mem_data_i and go to RESP.
  - RESP: c_ack_o=1, c_data_o = latched line, then go to IDLE.
- mem_addr_o, mem_data_o and mem_write_o stay stable while mem_enable_o=1. mem_enable_o deasserts in the cycle after mem_ack_i.
- c_ack_o is never high on two consecutive cycles. One cache request completes at a time.
- Writes accepted during DRAIN or READ are legal, since the FIFO is independent of the FSM.
- A cache write to the tag of the head while it drains allocates a new entry, so the newest data wins after both writes land in memory.

Test Plan:
- Write-back absorb: cache writes line 0x0400 with data 256'hA5..A5, memory latency 10 -> c_ack_o at cycle+1, count_o=1. Memory write to 0x0400 completes. count_o=0, empty_o=1.
- Forwarding: write line 0x0200 = 256'h1234.., then immediately read 0x0204 -> c_ack_o 1 cycle later, c_data_o=256'h1234.., no mem_enable_o with mem_write_o=0 issued.
- Merge: write 0x0020 with X then 0x0020 with Y while head 0x0000 drains -> count_o stays 2. Memory finally holds Y at line 1.
- Full stall: 5 writes to distinct lines with DEPTH=4 -> 5th c_ack_o delayed until 1 cycle after the first pop. Memory receives the lines in issue order.
- Read priority: 2 entries queued, FSM in IDLE, read miss to 0x0040 -> READ issued before any drain. c_data_o = memory line 2 (ECFA pattern). Drains follow.
- Reset mid-DRAIN: assert rst_i=0 while mem_enable_o=1 -> mem_enable_o=0 asynchronously, count_o=0, empty_o=1. No c_ack_o after release.

Source files
------------

// File: rtl/dcache_wb_buffer.sv
// rtl/dcache_wb_buffer.sv - write-back line buffer between the data cache and Data_Memory
// Evictions are acked in one cycle and drained in the background; read misses bypass queued writes.
module dcache_wb_buffer #(
   parameter int DEPTH  = 4,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [ADDR_W-1:0]      c_addr_i,
   input  logic [LINE_W-1:0]      c_data_i,
   input  logic                   c_enable_i,
   input  logic                   c_write_i,
   output logic                   c_ack_o,
   output logic [LINE_W-1:0]      c_data_o,
   output logic [ADDR_W-1:0]      mem_addr_o,
   output logic [LINE_W-1:0]      mem_data_o,
   output logic                   mem_enable_o,
   output logic                   mem_write_o,
   input  logic                   mem_ack_i,
   input  logic [LINE_W-1:0]      mem_data_i,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int TAG_W = ADDR_W - 5;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;
   state_t state, state_next;

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [LINE_W-1:0] line_mem [DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic [PTR_W:0]    count;
   logic              ack_q;
   logic [LINE_W-1:0] c_data_q;

   logic [TAG_W-1:0]  c_tag;
   logic              addr_lsb_unused;
   logic [DEPTH-1:0]  valid, rd_match, wr_match;
   logic [PTR_W-1:0]  rd_idx, wr_idx;
   logic              rd_hit, wr_hit;
   logic              req_ok, wr_req, rd_req, push, merge, rd_hit_ack, rd_miss, pop;

   assign c_tag           = c_addr_i[ADDR_W-1:5];
   assign addr_lsb_unused = ^c_addr_i[4:0];

   // A draining head is visible to reads but closed to merges, so a rewrite of its tag allocates.
   always_comb begin
      valid    = '0;
      rd_match = '0;
      wr_match = '0;
      wr_idx   = '0;
      wr_hit   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i]    = {1'b0, PTR_W'(PTR_W'(i) - head)} < count;
         rd_match[i] = valid[i] && (tag_mem[i] == c_tag);
         wr_match[i] = rd_match[i] && !((PTR_W'(i) == head) && (state == DRAIN));
         if (wr_match[i]) begin
            wr_hit = 1'b1;
            wr_idx = PTR_W'(i);
         end
      end
      rd_hit = |rd_match;
      rd_idx = wr_hit ? wr_idx : head;
   end

   assign req_ok     = c_enable_i && !ack_q && (state != RESP) && !((state == READ) && mem_ack_i);
   assign wr_req     = req_ok && c_write_i;
   assign rd_req     = req_ok && !c_write_i && (state != READ);
   assign merge      = wr_req && wr_hit;
   assign push       = wr_req && !wr_hit && (count != FULL_CNT);
   assign rd_hit_ack = rd_req && rd_hit;
   assign rd_miss    = rd_req && !rd_hit;
   assign pop        = (state == DRAIN) && mem_ack_i;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      case (state)
         IDLE: begin
            if (rd_miss)           state_next = READ;
            else if (count != '0)  state_next = DRAIN;
         end
         DRAIN: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_mem[head], 5'b0};
            mem_data_o   = line_mem[head];
            if (mem_ack_i) state_next = IDLE;
         end
         READ: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {c_tag, 5'b0};
            if (mem_ack_i) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         ack_q    <= 1'b0;
         c_data_q <= '0;
      end else begin
         ack_q <= push || merge || rd_hit_ack;
         if (rd_hit_ack)                        c_data_q <= line_mem[rd_idx];
         else if ((state == READ) && mem_ack_i) c_data_q <= mem_data_i;
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         tag_mem[tail]  <= c_tag;
         line_mem[tail] <= c_data_i;
      end
      if (merge) line_mem[wr_idx] <= c_data_i;
   end

   assign c_ack_o  = ack_q || (state == RESP);
   assign c_data_o = c_data_q;
   assign count_o  = count;
   assign empty_o  = (count == '0) && (state != DRAIN);
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// tb/tb_dcache_wb_buffer.sv - bench for dcache_wb_buffer against a line-level memory model
module tb_dcache_wb_buffer;
   localparam int DEPTH  = 4;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   typedef struct packed { logic w; logic [31:0] a; } txn_t;

   logic              clk = 1'b0;
   logic              rst_n, c_enable, c_write, c_ack, mem_enable, mem_write, mem_ack, empty;
   logic [31:0]       c_addr, mem_addr;
   logic [255:0]      c_wdata, c_rdata, mem_wdata, mem_rdata;
   logic [2:0]        count;

   int                checks = 0, errors = 0, cyc = 0, mem_lat = 4, wcnt = 0, n_reads = 0;
   logic [255:0]      mem [int];
   logic [255:0]      shadow [int];
   txn_t              txlog[$];
   int                wr_ack_cyc[$];
   logic [288:0]      snap;
   logic              prev_ack = 1'b0;

   dcache_wb_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .c_addr_i(c_addr), .c_data_i(c_wdata), .c_enable_i(c_enable), .c_write_i(c_write),
      .c_ack_o(c_ack), .c_data_o(c_rdata),
      .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_enable_o(mem_enable),
      .mem_write_o(mem_write), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
      .count_o(count), .empty_o(empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] init_line(input int tag);
      logic [15:0] t;
      t = 16'(tag);
      return {8{16'hECFA, t}};
   endfunction

   function automatic logic [255:0] mem_rd(input int tag);
      if (mem.exists(tag)) return mem[tag];
      return init_line(tag);
   endfunction

   function automatic logic [255:0] shadow_rd(input int tag);
      if (shadow.exists(tag)) return shadow[tag];
      return init_line(tag);
   endfunction

   // Memory side: fixed-latency responder that also checks request stability.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
            checks++;
            if (mem_enable !== 1'b0) begin
               errors++;
               $display("FAIL mem_enable_after_ack: got %b want 0", mem_enable);
            end
         end else if (mem_enable) begin
            checks++;
            if (wcnt == 0) begin
               snap = {mem_write, mem_addr, mem_wdata};
               if (mem_addr[4:0] !== 5'd0) begin
                  errors++;
                  $display("FAIL mem_addr_align: got %h want low 5 bits 0", mem_addr);
               end
            end else if ({mem_write, mem_addr, mem_wdata} !== snap) begin
               errors++;
               $display("FAIL mem_req_stable: addr %h write %b changed from %h", mem_addr, mem_write, snap[287:256]);
            end
            wcnt++;
            if (wcnt >= mem_lat) begin
               mem_ack = 1'b1;
               txlog.push_back({mem_write, mem_addr});
               if (mem_write) begin
                  mem[int'(mem_addr >> 5)] = mem_wdata;
                  wr_ack_cyc.push_back(cyc);
               end else begin
                  mem_rdata = mem_rd(int'(mem_addr >> 5));
                  n_reads++;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && c_ack) begin
            checks++;
            if (prev_ack) begin
               errors++;
               $display("FAIL ack_back_to_back: got two consecutive c_ack cycles want one");
            end
         end
         prev_ack = rst_n && c_ack;
      end
   end

   task automatic cache_req(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                            output logic [255:0] rdata, output int lat, output int ack_cyc);
      @(posedge clk); #1;
      c_enable = 1'b1;
      c_write  = wr;
      c_addr   = addr;
      c_wdata  = data;
      lat = 0;
      @(negedge clk);
      while (!c_ack && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      if (!c_ack) begin
         errors++;
         $display("FAIL cache_req_timeout: addr %h got no c_ack want ack", addr);
      end
      rdata   = c_rdata;
      ack_cyc = cyc;
      @(posedge clk); #1;
      c_enable = 1'b0;
      c_write  = 1'b0;
   endtask

   task automatic wait_empty();
      int n = 0;
      @(negedge clk);
      while (!empty && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!empty) begin
         errors++;
         $display("FAIL drain_timeout: got empty=%b count=%0d want empty=1", empty, count);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; c_enable = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({c_ack, mem_enable, mem_write} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 000", {c_ack, mem_enable, mem_write});
      end
      checks++;
      if (c_rdata !== '0 || mem_wdata !== '0 || mem_addr !== '0) begin
         errors++; $display("FAIL reset_data: got addr %h want 0 and zero lines", mem_addr);
      end
      checks++;
      if (count !== 3'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL reset_count: got count %0d empty %b want 0 1", count, empty);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_absorb();
      logic [255:0] d, r;
      int lat, ac, base;
      mem_lat = 10; base = txlog.size();
      d = {32{8'hA5}};
      cache_req(1'b1, 32'h0400, d, r, lat, ac);
      shadow[32'h0400 >> 5] = d;
      checks++;
      if (lat != 1) begin errors++; $display("FAIL absorb_latency: got %0d want 1", lat); end
      checks++;
      if (count !== 3'd1) begin errors++; $display("FAIL absorb_count: got %0d want 1", count); end
      wait_empty();
      checks++;
      if (mem_rd(32'h0400 >> 5) !== d) begin errors++; $display("FAIL absorb_mem: got %h want %h", mem_rd(32), d); end
      checks++;
      if (txlog.size() != base + 1 || txlog[base] !== {1'b1, 32'h0400}) begin
         errors++; $display("FAIL absorb_txn: got %0d txns want 1 write to 0400", txlog.size() - base);
      end
   endtask

   task automatic test_forwarding();
      logic [255:0] d, r;
      int lat, ac, reads0;
      mem_lat = 10; reads0 = n_reads;
      d = {16{16'h1234}};
      cache_req(1'b1, 32'h0200, d, r, lat, ac);
      shadow[32'h0200 >> 5] = d;
      cache_req(1'b0, 32'h0204, '0, r, lat, ac);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL fwd_latency: got %0d want 1", lat); end
      checks++;
      if (r !== d) begin errors++; $display("FAIL fwd_data: got %h want %h", r, d); end
      checks++;
      if (n_reads != reads0) begin errors++; $display("FAIL fwd_no_mem_read: got %0d reads want 0", n_reads - reads0); end
      wait_empty();
   endtask

   task automatic test_merge();
      logic [255:0] a, x, y, b, r;
      int lat, ac, base;
      mem_lat = 30; base = txlog.size();
      a = {32{8'h11}}; x = {32{8'h22}}; y = {32{8'h33}}; b = {32{8'h44}};
      cache_req(1'b1, 32'h0000, a, r, lat, ac);
      cache_req(1'b1, 32'h0020, x, r, lat, ac);
      cache_req(1'b1, 32'h0020, y, r, lat, ac);
      checks++;
      if (count !== 3'd2 || lat != 1) begin errors++; $display("FAIL merge_count: got %0d lat %0d want 2 lat 1", count, lat); end
      cache_req(1'b1, 32'h0000, b, r, lat, ac);
      checks++;
      if (count !== 3'd3) begin errors++; $display("FAIL head_rewrite_alloc: got %0d want 3", count); end
      shadow[0] = b; shadow[1] = y;
      wait_empty();
      checks++;
      if (mem_rd(1) !== y) begin errors++; $display("FAIL merge_mem_line1: got %h want %h", mem_rd(1), y); end
      checks++;
      if (mem_rd(0) !== b) begin errors++; $display("FAIL head_rewrite_mem: got %h want %h", mem_rd(0), b); end
      checks++;
      if (txlog.size() != base + 3) begin errors++; $display("FAIL merge_txn_count: got %0d want 3", txlog.size() - base); end
   endtask

   task automatic test_full_stall();
      logic [255:0] d, r;
      logic [31:0]  a;
      int lat [5];
      int ac  [5];
      int base, wbase;
      mem_lat = 30; base = txlog.size(); wbase = wr_ack_cyc.size();
      for (int i = 0; i < 5; i++) begin
         a = 32'h1000 + 32'(i) * 32'h20;
         d = {8{32'hF000_0000 + 32'(i)}};
         cache_req(1'b1, a, d, r, lat[i], ac[i]);
         shadow[int'(a >> 5)] = d;
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (lat[i] != 1) begin errors++; $display("FAIL full_early_latency: write %0d got %0d want 1", i, lat[i]); end
      end
      checks++;
      if (wr_ack_cyc.size() <= wbase || ac[4] != wr_ack_cyc[wbase] + 2) begin
         errors++; $display("FAIL full_stall_ack: got cycle %0d want first pop cycle + 2", ac[4]);
      end
      wait_empty();
      for (int i = 0; i < 5; i++) begin
         a = 32'h1000 + 32'(i) * 32'h20;
         checks++;
         if (txlog.size() <= base + i || txlog[base + i] !== {1'b1, a} || mem_rd(int'(a >> 5)) !== {8{32'hF000_0000 + 32'(i)}}) begin
            errors++; $display("FAIL full_order: entry %0d want write to %h with its line", i, a);
         end
      end
   endtask

   task automatic test_read_priority();
      logic [255:0] r, exp_line;
      int lat, ac, base;
      mem_lat = 20; base = txlog.size();
      exp_line = {8{32'hECFA_0002}};
      for (int i = 0; i < 3; i++) begin
         cache_req(1'b1, 32'h0800 + 32'(i) * 32'h20, {8{32'hB000_0000 + 32'(i)}}, r, lat, ac);
         shadow[int'((32'h0800 + 32'(i) * 32'h20) >> 5)] = {8{32'hB000_0000 + 32'(i)}};
      end
      cache_req(1'b0, 32'h0040, '0, r, lat, ac);
      checks++;
      if (r !== exp_line) begin errors++; $display("FAIL read_miss_data: got %h want %h", r, exp_line); end
      checks++;
      if (txlog.size() < base + 2 || txlog[base] !== {1'b1, 32'h0800} || txlog[base + 1] !== {1'b0, 32'h0040}) begin
         errors++; $display("FAIL read_priority: second txn got %h want read of 0040", txlog[base + 1]);
      end
      wait_empty();
      checks++;
      if (txlog.size() != base + 4 || txlog[base + 2] !== {1'b1, 32'h0820} || txlog[base + 3] !== {1'b1, 32'h0840}) begin
         errors++; $display("FAIL drain_after_read: got %0d txns want 4 ending 0820 0840", txlog.size() - base);
      end
   endtask

   task automatic test_random();
      logic [255:0] d, r;
      logic [31:0]  a;
      int lat, ac, tag;
      for (int n = 0; n < 150; n++) begin
         mem_lat = $urandom_range(1, 6);
         tag = $urandom_range(0, 7);
         a = 32'(tag) * 32'h20 + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            cache_req(1'b1, a, d, r, lat, ac);
            shadow[tag] = d;
         end else begin
            cache_req(1'b0, a, '0, r, lat, ac);
            checks++;
            if (r !== shadow_rd(tag)) begin errors++; $display("FAIL rand_read: addr %h got %h want %h", a, r, shadow_rd(tag)); end
         end
         checks++;
         if (count > 3'(DEPTH)) begin errors++; $display("FAIL rand_count: got %0d want <= %0d", count, DEPTH); end
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_empty();
      for (int t = 0; t < 8; t++) begin
         checks++;
         if (mem_rd(t) !== shadow_rd(t)) begin errors++; $display("FAIL rand_final_mem: line %0d got %h want %h", t, mem_rd(t), shadow_rd(t)); end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [255:0] r;
      int lat, ac, n;
      logic seen;
      mem_lat = 20;
      cache_req(1'b1, 32'h3000, {32{8'h5A}}, r, lat, ac);
      n = 0;
      while (!mem_enable && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!mem_enable) begin errors++; $display("FAIL rst_drain_start: got mem_enable 0 want 1"); end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_enable !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin
         errors++; $display("FAIL rst_async: got en %b count %0d empty %b want 0 0 1", mem_enable, count, empty);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (c_ack || mem_enable) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL rst_quiet: got activity after reset want none"); end
      checks++;
      if (mem.exists(32'h3000 >> 5)) begin errors++; $display("FAIL rst_discard: got line 3000 written want discarded"); end
   endtask

   initial begin
      test_reset();
      test_absorb();
      test_forwarding();
      test_merge();
      test_full_stall();
      test_read_priority();
      test_random();
      test_reset_mid_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
